wb_frame_loader: RTL and testbench
==================================

Name: wb_frame_loader

Overview:
- Parametrised Wishbone pipelined master that streams an R-row frame from an external combinational pattern ROM into the matrix row-register file (a Wishbone slave).
- Supports NUM_FRAMES frames, next/prev/auto-advance selection, true ACK accounting, ACK timeout and bus-error abort.
- Sits between the user-input debouncers and the matrix register slave.
- Replaces the fixed two-picture, ack-ignoring loader.

Parameters:
- WB_DATA_WIDTH, 32, data bus width.
- REG_COUNT, 8, rows per frame; must be ≥2.
- WB_ADDR_WIDTH, $clog2(REG_COUNT), row address width.
- WB_SEL_WIDTH, WB_DATA_WIDTH/8, byte-select width.
- NUM_FRAMES, 4, number of frames; must be ≥2.
- FRAME_W, $clog2(NUM_FRAMES), frame index width.
- AUTO_PERIOD, 50000000, cycles between auto-advances; must be ≥1.
- ACK_TIMEOUT, 255, maximum cycles waiting for any ACK while transfers are outstanding.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_next  in  1  level input; a rising edge selects the next frame.
- i_prev  in  1  level input; a rising edge selects the previous frame.
- i_auto  in  1  enables periodic auto-advance.
- o_frame  out  FRAME_W  index of the last frame fully loaded.
- o_busy  out  1  high while o_wb_cyc is high.
- o_err  out  1  sticky: a load was aborted by timeout or bus error.
- o_rom_addr  out  FRAME_W+WB_ADDR_WIDTH  {load_frame, issue_row}.
- i_rom_data  in  WB_DATA_WIDTH  combinational ROM data for o_rom_addr.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone control.
- o_wb_addr  out  WB_ADDR_WIDTH  row address; equals issue_row.
- o_wb_sel  out  WB_SEL_WIDTH  all ones.
- o_wb_wdata  out  WB_DATA_WIDTH  equals i_rom_data.
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave responses.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: cyc/stb/we = 0, o_frame = 0, o_err = 0, o_busy = 0.
  - Internal: target = 0, pending = 1 (frame 0 loads after reset), state IDLE, all counters 0.
  - Edge registers reset to 0.
- Request generation:
  - Inputs are sampled via 1-cycle delayed copies; rise = in & ~prev.
  - next alone: target = (target+1) mod NUM_FRAMES.
  - prev alone: target = (target−1) mod NUM_FRAMES; 0 wraps to NUM_FRAMES−1.
  - next and prev in the same cycle: no change.
  - Auto counter: runs only while i_auto=1 and is cleared when i_auto=0. On reaching AUTO_PERIOD−1 it wraps to 0 and acts as a next. A coincident button edge takes priority and the auto tick is dropped.
  - Any target change sets pending.
- States:
  - IDLE: cyc = 0. If pending: clear pending, load_frame ← target, issue_row ← 0, outstanding ← 0; go to ISSUE next cycle.
  - ISSUE: cyc = stb = we = 1. beat = stb & ~i_wb_stall. On beat: issue_row++. On the beat with issue_row = REG_COUNT−1, go to DRAIN. Address and data are held stable while stalled.
  - DRAIN: cyc = 1, stb = 0. When outstanding = 0 (including the same cycle the final ack arrives): o_frame ← load_frame, go to IDLE.
- Outstanding counter:
  - Width $clog2(REG_COUNT+1); updated each cycle by +beat −ack.
  - An ACK arriving with outstanding = 0 and no beat in that cycle is ignored.
- Abort:
  - Trigger 1: i_wb_err while cyc.
  - Trigger 2: a timeout counter that increments each cycle with cyc & outstanding≠0 & ~ack, and clears on any ack, reaches ACK_TIMEOUT.
  - Action: next cycle cyc/stb = 0, state IDLE, o_err = 1, o_frame unchanged.
  - A pending request present at abort is serviced normally afterwards.
- Requests during a load: update target and set pending; the current load completes, then the new target loads. Multiple requests collapse to the latest target.
- Latency: a request edge in cycle N gives stb high in cycle N+2 (edge register, then IDLE accept).
- Reset mid-load: the bus is dropped immediately (async) and frame 0 reloads after release.
- o_busy = o_wb_cyc.

Test Plan:
- Reset, slave acks 1 cycle after each beat, no stall → 8 beats to addr 0..7 with ROM data for frame 0, o_frame = 0, cyc low after the last ack, o_err = 0.
- Pulse i_next three times, waiting between loads (NUM_FRAMES=4) → o_frame 1, 2, 3. A fourth pulse wraps to 0. i_prev from 0 → 3.
- Stall asserted on row 3 for 5 cycles → addr and wdata held at row 3, exactly 8 beats, no duplicate or skipped row.
- i_next twice during an active load → current load finishes, then exactly one further load of target+2.
- Slave never acks, ACK_TIMEOUT = 15 → cyc drops 16 cycles after the first beat, o_err = 1, o_frame unchanged.
- i_auto = 1, AUTO_PERIOD = 20 → a load starts every 20 cycles. Dropping i_auto stops loads and clears the counter. reset_n asserted mid-burst → cyc = 0 within the same cycle.

Source files
------------

// File: rtl/wb_frame_loader.sv
// wb_frame_loader: Wishbone pipelined master streaming a selectable ROM frame into the row-register file.
module wb_frame_loader #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int REG_COUNT     = 8,
  parameter int WB_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
  parameter int NUM_FRAMES    = 4,
  parameter int FRAME_W       = $clog2(NUM_FRAMES),
  parameter int AUTO_PERIOD   = 50000000,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             i_next,
  input  logic                             i_prev,
  input  logic                             i_auto,
  output logic [FRAME_W-1:0]               o_frame,
  output logic                             o_busy,
  output logic                             o_err,
  output logic [FRAME_W+WB_ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [WB_DATA_WIDTH-1:0]         i_rom_data,
  output logic                             o_wb_cyc,
  output logic                             o_wb_stb,
  output logic                             o_wb_we,
  output logic [WB_ADDR_WIDTH-1:0]         o_wb_addr,
  output logic [WB_SEL_WIDTH-1:0]          o_wb_sel,
  output logic [WB_DATA_WIDTH-1:0]         o_wb_wdata,
  input  logic                             i_wb_ack,
  input  logic                             i_wb_stall,
  input  logic                             i_wb_err
);
  localparam int OW = $clog2(REG_COUNT + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int AW = $clog2(AUTO_PERIOD + 1);
  localparam logic [WB_ADDR_WIDTH-1:0] LAST_ROW   = WB_ADDR_WIDTH'(REG_COUNT - 1);
  localparam logic [FRAME_W-1:0]       LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [AW-1:0]            AUTO_LAST  = AW'(AUTO_PERIOD - 1);
  localparam logic [TW-1:0]            TMO_LIM    = TW'(ACK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic next_q, prev_q, pending_q, pending_d, err_q, err_d;
  logic [FRAME_W-1:0] target_q, target_d, load_q, load_d, frame_q, frame_d;
  logic [WB_ADDR_WIDTH-1:0] row_q, row_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] auto_q, auto_d;
  logic rise_n, rise_p, tick, fwd, back, beat, ack, dec, accept, abort, done;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      next_q    <= 1'b0;
      prev_q    <= 1'b0;
      pending_q <= 1'b1;
      err_q     <= 1'b0;
      target_q  <= '0;
      load_q    <= '0;
      frame_q   <= '0;
      row_q     <= '0;
      outst_q   <= '0;
      tmo_q     <= '0;
      auto_q    <= '0;
    end else begin
      state_q   <= state_d;
      next_q    <= i_next;
      prev_q    <= i_prev;
      pending_q <= pending_d;
      err_q     <= err_d;
      target_q  <= target_d;
      load_q    <= load_d;
      frame_q   <= frame_d;
      row_q     <= row_d;
      outst_q   <= outst_d;
      tmo_q     <= tmo_d;
      auto_q    <= auto_d;
    end
  always_comb begin
    rise_n    = i_next & ~next_q;
    rise_p    = i_prev & ~prev_q;
    tick      = i_auto && auto_q == AUTO_LAST;
    auto_d    = (i_auto && !tick) ? auto_q + 1'b1 : '0;
    // a button edge in the same cycle swallows the auto tick
    fwd       = (rise_n & ~rise_p) | (tick & ~rise_n & ~rise_p);
    back      = rise_p & ~rise_n;
    target_d  = fwd  ? (target_q == LAST_FRAME ? '0 : target_q + 1'b1) :
                back ? (target_q == '0 ? LAST_FRAME : target_q - 1'b1) : target_q;
    accept    = state_q == IDLE && pending_q;
    pending_d = fwd | back | (pending_q & ~accept);
    beat      = o_wb_stb & ~i_wb_stall;
    ack       = o_wb_cyc & i_wb_ack;
    dec       = ack & ((outst_q != '0) | beat);
    outst_d   = accept ? '0 : outst_q + OW'(beat) - OW'(dec);
    tmo_d     = (!o_wb_cyc || ack) ? '0 : tmo_q + TW'(outst_q != '0);
    abort     = o_wb_cyc & (i_wb_err | (tmo_d == TMO_LIM));
    done      = state_q == DRAIN && outst_d == '0;
    row_d     = accept ? '0 : row_q + WB_ADDR_WIDTH'(beat);
    load_d    = accept ? target_q : load_q;
    frame_d   = (done && !abort) ? load_q : frame_q;
    err_d     = err_q | abort;
    state_d   = abort  ? IDLE :
                accept ? ISSUE :
                (state_q == ISSUE && beat && row_q == LAST_ROW) ? DRAIN :
                done   ? IDLE : state_q;
  end
  always_comb begin
    o_wb_cyc   = state_q != IDLE;
    o_wb_stb   = state_q == ISSUE;
    o_wb_we    = state_q == ISSUE;
    o_wb_addr  = row_q;
    o_wb_sel   = '1;
    o_wb_wdata = i_rom_data;
    o_rom_addr = {load_q, row_q};
    o_busy     = o_wb_cyc;
    o_frame    = frame_q;
    o_err      = err_q;
  end
endmodule

// File: tb/tb_wb_frame_loader.sv
// tb_wb_frame_loader: directed scenario tests for wb_frame_loader with a pipelined slave model.
module tb_wb_frame_loader;
  logic clk = 1'b0, reset_n = 1'b0, i_next = 1'b0, i_prev = 1'b0, i_auto = 1'b0;
  logic [1:0] o_frame;
  logic o_busy, o_err, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [4:0] o_rom_addr;
  logic [31:0] i_rom_data, o_wb_wdata;
  logic [2:0] o_wb_addr;
  logic [3:0] o_wb_sel;
  logic i_wb_ack = 1'b0, i_wb_stall = 1'b0, i_wb_err = 1'b0;
  int tests = 0, fails = 0;
  bit ack_en = 1'b1, beat_prev = 1'b0, cyc_prev = 1'b0;
  int stall_left = 0, cnt = 0, fall_t = 0;
  int b_addr[$], b_time[$], st_addr[$];
  logic [31:0] b_data[$], st_data[$];

  wb_frame_loader #(
    .WB_DATA_WIDTH(32), .REG_COUNT(8), .NUM_FRAMES(4), .AUTO_PERIOD(20), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_next(i_next), .i_prev(i_prev), .i_auto(i_auto),
    .o_frame(o_frame), .o_busy(o_busy), .o_err(o_err), .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_sel(o_wb_sel), .o_wb_wdata(o_wb_wdata),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err)
  );

  always #5 clk = ~clk;
  assign i_rom_data = {16'hA5C3, 6'd0, o_rom_addr[4:3], 5'd0, o_rom_addr[2:0]};

  function automatic logic [31:0] rom(input int f, input int r);
    return 32'hA5C3_0000 | 32'(f << 8) | 32'(r);
  endfunction

  // slave: acks each beat one cycle later, optional stall on row 3, logs beats
  initial begin
    forever begin
      @(negedge clk);
      cnt++;
      if (!reset_n) begin
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; beat_prev = 1'b0; cyc_prev = 1'b0;
      end else begin
        i_wb_ack = ack_en & beat_prev;
        i_wb_stall = 1'b0;
        if (o_wb_stb && o_wb_addr == 3'd3 && stall_left > 0) begin
          i_wb_stall = 1'b1;
          stall_left--;
          st_addr.push_back(int'(o_wb_addr));
          st_data.push_back(o_wb_wdata);
        end
        beat_prev = o_wb_cyc & o_wb_stb & ~i_wb_stall;
        if (beat_prev) begin
          b_addr.push_back(int'(o_wb_addr)); b_data.push_back(o_wb_wdata); b_time.push_back(cnt);
        end
        if (cyc_prev && !o_wb_cyc) fall_t = cnt;
        cyc_prev = o_wb_cyc;
      end
    end
  end

  task automatic clear_q;
    b_addr.delete(); b_data.delete(); b_time.delete(); st_addr.delete(); st_data.delete();
  endtask

  task automatic press(input bit nxt);
    @(negedge clk); i_next = nxt; i_prev = !nxt;
    @(negedge clk); i_next = 1'b0; i_prev = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100 && !o_wb_cyc; k++) @(negedge clk);
    if (o_wb_cyc) begin
      for (int k = 0; k < 100 && o_wb_cyc; k++) @(negedge clk);
      ok = !o_wb_cyc;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    bit ok;
    repeat (3) @(negedge clk);
    tests++; if (o_wb_cyc !== 1'b0) begin fails++; $display("FAIL reset_cyc: got %b want 0", o_wb_cyc); end
    tests++; if (o_wb_stb !== 1'b0) begin fails++; $display("FAIL reset_stb: got %b want 0", o_wb_stb); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    tests++; if (o_frame !== 2'd0) begin fails++; $display("FAIL reset_frame: got %0d want 0", o_frame); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", o_err); end
    clear_q();
    reset_n = 1'b1;
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL boot_done: load did not finish in time"); end
    tests++; if (b_addr.size() != 8) begin fails++; $display("FAIL boot_beats: got %0d want 8", b_addr.size()); end
    for (int r = 0; r < 8; r++) begin
      tests++;
      if (r >= b_addr.size() || b_addr[r] != r || b_data[r] !== rom(0, r)) begin
        fails++; $display("FAIL boot_row%0d: got addr %0d data %h want addr %0d data %h", r, b_addr[r], b_data[r], r, rom(0, r));
      end
    end
    tests++; if (o_frame !== 2'd0) begin fails++; $display("FAIL boot_frame: got %0d want 0", o_frame); end
    tests++; if (o_err !== 1'b0 || o_wb_cyc !== 1'b0) begin fails++; $display("FAIL boot_end: got err %b cyc %b want 0 0", o_err, o_wb_cyc); end
  endtask

  task automatic test_next;
    for (int i = 1; i <= 5; i++) begin
      int lat;
      int want;
      bit ok;
      want = (i <= 4) ? i % 4 : 3;
      clear_q();
      @(negedge clk); i_next = (i <= 4); i_prev = (i > 4); lat = -1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) begin i_next = 1'b0; i_prev = 1'b0; end
        if (o_wb_stb && lat < 0) lat = k;
      end
      tests++; if (lat != 2) begin fails++; $display("FAIL sel%0d_latency: got %0d want 2", i, lat); end
      wait_done(ok);
      tests++; if (!ok) begin fails++; $display("FAIL sel%0d_done: load did not finish in time", i); end
      tests++; if (o_frame !== 2'(want)) begin fails++; $display("FAIL sel%0d_frame: got %0d want %0d", i, o_frame, want); end
      tests++;
      if (b_addr.size() != 8 || b_data[0] !== rom(want, 0) || b_data[7] !== rom(want, 7) || b_addr[7] != 7) begin
        fails++; $display("FAIL sel%0d_beats: got %0d beats first %h want 8 beats first %h", i, b_addr.size(), b_data[0], rom(want, 0));
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    clear_q();
    stall_left = 5;
    press(1'b1);
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL stall_done: load did not finish in time"); end
    tests++; if (st_addr.size() != 5) begin fails++; $display("FAIL stall_cycles: got %0d want 5", st_addr.size()); end
    for (int j = 0; j < st_addr.size(); j++) begin
      tests++;
      if (st_addr[j] != 3 || st_data[j] !== rom(0, 3)) begin
        fails++; $display("FAIL stall_hold%0d: got addr %0d data %h want addr 3 data %h", j, st_addr[j], st_data[j], rom(0, 3));
      end
    end
    tests++; if (b_addr.size() != 8) begin fails++; $display("FAIL stall_beats: got %0d want 8", b_addr.size()); end
    for (int r = 0; r < 8; r++) begin
      tests++;
      if (r >= b_addr.size() || b_addr[r] != r || b_data[r] !== rom(0, r)) begin
        fails++; $display("FAIL stall_row%0d: got addr %0d data %h want addr %0d data %h", r, b_addr[r], b_data[r], r, rom(0, r));
      end
    end
    tests++; if (o_frame !== 2'd0) begin fails++; $display("FAIL stall_frame: got %0d want 0", o_frame); end
  endtask

  task automatic test_back_to_back;
    clear_q();
    press(1'b1);
    repeat (2) @(negedge clk);
    press(1'b1);
    press(1'b1);
    repeat (60) @(negedge clk);
    tests++; if (b_addr.size() != 16) begin fails++; $display("FAIL b2b_beats: got %0d want 16", b_addr.size()); end
    tests++;
    if (b_addr.size() < 16 || b_data[0] !== rom(1, 0) || b_data[7] !== rom(1, 7)) begin
      fails++; $display("FAIL b2b_first: got %h want %h", b_data[0], rom(1, 0));
    end
    tests++;
    if (b_addr.size() < 16 || b_data[8] !== rom(3, 0) || b_data[15] !== rom(3, 7)) begin
      fails++; $display("FAIL b2b_second: got %h want %h", b_data[8], rom(3, 0));
    end
    tests++; if (o_frame !== 2'd3) begin fails++; $display("FAIL b2b_frame: got %0d want 3", o_frame); end
    tests++; if (o_wb_cyc !== 1'b0) begin fails++; $display("FAIL b2b_idle: got cyc %b want 0", o_wb_cyc); end
  endtask

  task automatic test_timeout;
    bit ok;
    ack_en = 1'b0;
    clear_q();
    press(1'b1);
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL tmo_done: cyc never dropped"); end
    tests++; if (b_addr.size() != 8) begin fails++; $display("FAIL tmo_beats: got %0d want 8", b_addr.size()); end
    tests++;
    if (b_time.size() == 0 || fall_t - b_time[0] != 16) begin
      fails++; $display("FAIL tmo_delay: got %0d want 16", fall_t - b_time[0]);
    end
    tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b want 1", o_err); end
    tests++; if (o_frame !== 2'd3) begin fails++; $display("FAIL tmo_frame: got %0d want 3", o_frame); end
    ack_en = 1'b1;
  endtask

  task automatic test_auto;
    clear_q();
    @(negedge clk); i_auto = 1'b1;
    repeat (65) @(negedge clk);
    i_auto = 1'b0;
    repeat (50) @(negedge clk);
    tests++; if (b_addr.size() != 24) begin fails++; $display("FAIL auto_beats: got %0d want 24", b_addr.size()); end
    tests++;
    if (b_addr.size() < 24 || b_data[0] !== rom(1, 0) || b_data[8] !== rom(2, 0) || b_data[16] !== rom(3, 0)) begin
      fails++; $display("FAIL auto_frames: got %h %h %h want %h %h %h", b_data[0], b_data[8], b_data[16], rom(1, 0), rom(2, 0), rom(3, 0));
    end
    tests++;
    if (b_time.size() < 24 || b_time[8] - b_time[0] != 20 || b_time[16] - b_time[8] != 20) begin
      fails++; $display("FAIL auto_period: got %0d %0d want 20 20", b_time[8] - b_time[0], b_time[16] - b_time[8]);
    end
    tests++; if (o_frame !== 2'd3) begin fails++; $display("FAIL auto_frame: got %0d want 3", o_frame); end
    tests++; if (o_wb_cyc !== 1'b0) begin fails++; $display("FAIL auto_stop: got cyc %b want 0", o_wb_cyc); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit ok;
    lat = -1;
    @(negedge clk); i_auto = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (o_wb_stb) lat = k;
    end
    i_auto = 1'b0;
    tests++; if (lat != 21) begin fails++; $display("FAIL auto_restart: got %0d want 21", lat); end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++; if (o_wb_cyc !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL rst_mid_bus: got cyc %b busy %b want 0 0", o_wb_cyc, o_busy); end
    tests++; if (o_wb_stb !== 1'b0) begin fails++; $display("FAIL rst_mid_stb: got %b want 0", o_wb_stb); end
    repeat (2) @(negedge clk);
    tests++; if (o_frame !== 2'd0 || o_err !== 1'b0) begin fails++; $display("FAIL rst_mid_state: got frame %0d err %b want 0 0", o_frame, o_err); end
    clear_q();
    reset_n = 1'b1;
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_reload_done: load did not finish in time"); end
    tests++;
    if (b_addr.size() != 8 || b_data[0] !== rom(0, 0) || b_data[7] !== rom(0, 7)) begin
      fails++; $display("FAIL rst_reload: got %0d beats first %h want 8 beats first %h", b_addr.size(), b_data[0], rom(0, 0));
    end
    tests++; if (o_frame !== 2'd0) begin fails++; $display("FAIL rst_reload_frame: got %0d want 0", o_frame); end
  endtask

  task automatic test_bus_err;
    bit ok;
    press(1'b1);
    for (int k = 0; k < 10 && !o_wb_stb; k++) @(negedge clk);
    press(1'b1);
    @(negedge clk); i_wb_err = 1'b1;
    @(negedge clk); i_wb_err = 1'b0;
    tests++; if (o_wb_cyc !== 1'b0) begin fails++; $display("FAIL berr_drop: got cyc %b want 0", o_wb_cyc); end
    tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL berr_flag: got %b want 1", o_err); end
    tests++; if (o_frame !== 2'd0) begin fails++; $display("FAIL berr_frame: got %0d want 0", o_frame); end
    clear_q();
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL berr_pending_done: load did not finish in time"); end
    tests++;
    if (b_addr.size() != 8 || b_data[0] !== rom(2, 0) || b_data[7] !== rom(2, 7)) begin
      fails++; $display("FAIL berr_pending: got %0d beats first %h want 8 beats first %h", b_addr.size(), b_data[0], rom(2, 0));
    end
    tests++; if (o_frame !== 2'd2) begin fails++; $display("FAIL berr_pending_frame: got %0d want 2", o_frame); end
  endtask

  initial begin
    test_reset();
    test_next();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_auto();
    test_reset_mid();
    test_bus_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
